// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared constants, phase encoding and arithmetic helpers for the
//            streaming 3x3 convolution engine.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int KERNEL_TAPS  = 9;
    localparam int IDENTITY_TAP = 4;

    typedef enum logic [1:0] {
        PH_FILL  = 2'd0,
        PH_RUN   = 2'd1,
        PH_DRAIN = 2'd2
    } phase_t;

    // Nine-term sum of DATA_W x COEF_W products needs four guard bits.
    function automatic int acc_width(input int data_w, input int coef_w);
        return data_w + coef_w + 4;
    endfunction

    function automatic longint sat_signed(input longint value, input int out_w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

    function automatic longint identity_coef(input int tap);
        return (tap == IDENTITY_TAP) ? 64'sd1 : 64'sd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_stream_if
// Brief    : Pixel-in / pixel-out valid-ready bundle of the 3x3 convolver.
// Revision : 1.0 - initial release
// ============================================================================
interface conv3x3_stream_if #(
    parameter int DATA_W = 13,
    parameter int OUT_W  = 13
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_pixel;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_pixel;
    logic                     out_last;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_pixel, out_last
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_pixel, out_last
    );
endinterface
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : conv_line_buffer
// Brief    : Column-addressed two-row delay; outputs the pixels of the same
//            column one and two rows above the incoming one.
// Revision : 1.0 - initial release
// ============================================================================
module conv_line_buffer #(
    parameter int IMG_W  = 32,
    parameter int DATA_W = 13,
    parameter int COL_W  = $clog2(IMG_W)
) (
    input  wire logic                     clk,
    input  wire logic                     i_en,
    input  wire logic [COL_W-1:0]         i_col,
    input  wire logic signed [DATA_W-1:0] i_pixel,
    output logic signed [DATA_W-1:0]      o_lb1,
    output logic signed [DATA_W-1:0]      o_lb2
);
    logic signed [DATA_W-1:0] r_row1 [IMG_W];
    logic signed [DATA_W-1:0] r_row2 [IMG_W];

    assign o_lb1 = r_row1[i_col];
    assign o_lb2 = r_row2[i_col];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_row1[i_col] <= i_pixel;
            r_row2[i_col] <= r_row1[i_col];
        end
    end
endmodule
`default_nettype wire

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_stream
// Brief    : Streaming 3x3 signed convolution with loadable kernel, 3-stage
//            multiply / add / shift-saturate pipeline and backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int DATA_W  = 13,
    parameter int COEF_W  = 13,
    parameter int OUT_W   = 13,
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int FRAC_SH = 0
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     coef_we,
    input  wire logic [3:0]               coef_addr,
    input  wire logic signed [COEF_W-1:0] coef_data,
    conv3x3_stream_if.slave               stream,
    output logic                          busy
);
    localparam int ACC_W  = acc_width(DATA_W, COEF_W);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    phase_t           r_phase, w_phase_nxt;

    logic signed [COEF_W-1:0] r_bank [KERNEL_TAPS];
    logic signed [COEF_W-1:0] r_coef [KERNEL_TAPS];
    logic signed [DATA_W-1:0] r_win  [KERNEL_TAPS];
    logic signed [PROD_W-1:0] r_prod [KERNEL_TAPS];
    logic signed [ACC_W-1:0]  r_sum, w_sum, w_shift;
    logic signed [OUT_W-1:0]  w_sat, r_out_pixel;
    logic signed [DATA_W-1:0] w_lb1, w_lb2;

    logic r_win_v, r_win_last, r_s1_v, r_s1_last, r_s2_v, r_s2_last;
    logic r_out_valid, r_out_last;
    logic w_advance, w_accept, w_row_end, w_frame_end, w_first, w_pipe_empty;

    assign w_advance    = !r_out_valid | stream.out_ready;
    assign w_accept     = stream.in_valid & w_advance;
    assign w_row_end    = (r_col == COL_W'(IMG_W - 1));
    assign w_frame_end  = w_row_end && (r_row == ROW_W'(IMG_H - 1));
    assign w_first      = (r_row == '0) && (r_col == '0);
    assign w_pipe_empty = !(r_win_v | r_s1_v | r_s2_v | r_out_valid);

    assign stream.in_ready  = w_advance;
    assign stream.out_valid = r_out_valid;
    assign stream.out_pixel = r_out_pixel;
    assign stream.out_last  = r_out_last;
    assign busy = (r_phase != PH_FILL) || (r_row != '0) || (r_col != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_row_end) begin
                r_col <= '0;
                r_row <= (r_row == ROW_W'(IMG_H - 1)) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Shadow copy reads the bank before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                r_bank[k] <= COEF_W'(identity_coef(k));
                r_coef[k] <= COEF_W'(identity_coef(k));
            end
        end else begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                if (coef_we && (coef_addr == 4'(k))) r_bank[k] <= coef_data;
                if (w_accept && w_first)             r_coef[k] <= r_bank[k];
            end
        end
    end

    conv_line_buffer #(.IMG_W(IMG_W), .DATA_W(DATA_W), .COL_W(COL_W)) u_line_buffer (
        .clk     (clk),
        .i_en    (w_accept),
        .i_col   (r_col),
        .i_pixel (stream.in_pixel),
        .o_lb1   (w_lb1),
        .o_lb2   (w_lb2)
    );

    // Window index = row*3 + col, row 0 on top, col 2 newest.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_win[3*r]     <= r_win[3*r + 1];
                r_win[3*r + 1] <= r_win[3*r + 2];
            end
            r_win[2] <= w_lb2;
            r_win[5] <= w_lb1;
            r_win[8] <= stream.in_pixel;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            w_sum = w_sum + ACC_W'(r_prod[k]);
        end
    end

    assign w_shift = r_sum >>> FRAC_SH;
    assign w_sat   = OUT_W'(sat_signed(longint'(w_shift), OUT_W));

    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                r_prod[k] <= PROD_W'(r_win[k]) * PROD_W'(r_coef[k]);
            end
            r_sum <= w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_v     <= 1'b0;
            r_win_last  <= 1'b0;
            r_s1_v      <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_v      <= 1'b0;
            r_s2_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_pixel <= '0;
        end else if (w_advance) begin
            r_win_v     <= w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
            r_win_last  <= w_accept && w_frame_end;
            r_s1_v      <= r_win_v;
            r_s1_last   <= r_win_last;
            r_s2_v      <= r_s1_v;
            r_s2_last   <= r_s1_last;
            r_out_valid <= r_s2_v;
            r_out_last  <= r_s2_v && r_s2_last;
            if (r_s2_v) r_out_pixel <= w_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_phase <= PH_FILL;
        else        r_phase <= w_phase_nxt;
    end

    always_comb begin
        w_phase_nxt = r_phase;
        case (r_phase)
            PH_FILL:  if (w_accept && (r_row == ROW_W'(2)) && (r_col == '0)) w_phase_nxt = PH_RUN;
            PH_RUN:   if (w_accept && w_frame_end)                           w_phase_nxt = PH_DRAIN;
            PH_DRAIN: if (w_accept || w_pipe_empty)                          w_phase_nxt = PH_FILL;
            default:  w_phase_nxt = PH_FILL;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_stream
// Brief    : Directed bench for conv3x3_stream on a 5x4 image (two instances,
//            FRAC_SH=0 and FRAC_SH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv3x3_stream;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic signed [12:0] coef_data;
    logic              busy_a, busy_b;

    int total = 0;
    int bad   = 0;
    int qa_pix[$], qb_pix[$];
    bit qa_last[$], qb_last[$];
    int exp_q[$];

    always #5 clk = ~clk;

    conv3x3_stream_if #(.DATA_W(13), .OUT_W(13)) ifa ();
    conv3x3_stream_if #(.DATA_W(13), .OUT_W(13)) ifb ();

    conv3x3_stream #(.IMG_W(5), .IMG_H(4), .FRAC_SH(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .stream(ifa), .busy(busy_a)
    );

    conv3x3_stream #(.IMG_W(5), .IMG_H(4), .FRAC_SH(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .stream(ifb), .busy(busy_b)
    );

    always @(posedge clk) begin
        if (ifa.out_valid && ifa.out_ready) begin
            qa_pix.push_back(int'(ifa.out_pixel));
            qa_last.push_back(ifa.out_last);
        end
        if (ifb.out_valid && ifb.out_ready) begin
            qb_pix.push_back(int'(ifb.out_pixel));
            qb_last.push_back(ifb.out_last);
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input bit sel, input int px);
        int t;
        t = 0;
        @(negedge clk);
        if (sel) begin ifb.in_valid = 1'b1; ifb.in_pixel = 13'(px); end
        else     begin ifa.in_valid = 1'b1; ifa.in_pixel = 13'(px); end
        #1;
        while (!(sel ? ifb.in_ready : ifa.in_ready)) begin
            @(negedge clk);
            #1;
            t++;
            if (t > 200) begin
                total++;
                bad++;
                $error("FAIL push_timeout observed=%0d expected=%0d", t, 200);
                return;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
    endtask

    // mode 0: ramp 10*r+c over pixel indices [lo,hi); mode 1: constant val
    task automatic stream_px(input bit sel, input bit mode, input int val, input int lo, input int hi);
        for (int i = lo; i < hi; i++) push(sel, mode ? val : 10 * (i / 5) + (i % 5));
    endtask

    task automatic write_kernel(input bit ones);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            coef_we   = 1'b1;
            coef_addr = 4'(k);
            coef_data = (ones || k == 4) ? 13'sd1 : 13'sd0;
        end
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic wait_outs(input bit sel, input int n);
        int t;
        t = 0;
        while (((sel ? qb_pix.size() : qa_pix.size()) < n) && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        chk("out_count", sel ? qb_pix.size() : qa_pix.size(), n);
    endtask

    task automatic check_seq(input bit sel, input string tag, input int lasts);
        for (int i = 0; i < exp_q.size(); i++) begin
            int  sz;
            int  p;
            bit  l;
            sz = sel ? qb_pix.size() : qa_pix.size();
            p  = (i < sz) ? (sel ? qb_pix[i] : qa_pix[i]) : -99999;
            l  = (i < sz) ? (sel ? qb_last[i] : qa_last[i]) : 1'b0;
            chk($sformatf("%s_pix%0d", tag, i), p, exp_q[i]);
            chk($sformatf("%s_last%0d", tag, i), 32'(l), ((i % 6 == 5) && (i / 6 < lasts)) ? 1 : 0);
        end
    endtask

    task automatic clear_q();
        qa_pix.delete(); qa_last.delete();
        qb_pix.delete(); qb_last.delete();
    endtask

    initial begin
        rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        ifa.in_valid = 1'b0; ifa.in_pixel = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_pixel = '0; ifb.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(ifa.out_valid), 0);
        chk("rst_out_pixel", ifa.out_pixel, 0);
        chk("rst_out_last",  32'(ifa.out_last), 0);
        chk("rst_busy",      32'(busy_a), 0);
        rst_n = 1'b1;

        // 1: identity kernel, ramp image, latency from accept of (2,2)
        clear_q();
        stream_px(0, 0, 0, 0, 13);
        idle();
        chk("lat_e0_valid", 32'(ifa.out_valid), 0);
        @(negedge clk);
        chk("lat_e1_valid", 32'(ifa.out_valid), 0);
        @(negedge clk);
        chk("lat_e2_valid", 32'(ifa.out_valid), 0);
        @(negedge clk);
        chk("lat_e3_valid", 32'(ifa.out_valid), 1);
        chk("lat_e3_pixel", ifa.out_pixel, 11);
        chk("run_busy", 32'(busy_a), 1);
        stream_px(0, 0, 0, 13, 20);
        idle();
        wait_outs(0, 6);
        exp_q = '{11, 12, 13, 21, 22, 23};
        check_seq(0, "ident", 1);
        chk("idle_busy", 32'(busy_a), 0);

        // 2: all-ones kernel saturates both ways
        write_kernel(1'b1);
        clear_q();
        stream_px(0, 1, 500, 0, 20);
        stream_px(0, 1, -500, 0, 20);
        idle();
        wait_outs(0, 12);
        exp_q = {};
        for (int i = 0; i < 12; i++) exp_q.push_back(i < 6 ? 4095 : -4096);
        check_seq(0, "sat", 2);

        // 3: 5-cycle output stall while 12 is presented
        write_kernel(1'b0);
        clear_q();
        fork
            begin
                stream_px(0, 0, 0, 0, 20);
                idle();
            end
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!(qa_pix.size() == 1 && ifa.out_valid) && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                ifa.out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready",  32'(ifa.in_ready), 0);
                    chk("stall_out_valid", 32'(ifa.out_valid), 1);
                    chk("stall_out_pixel", ifa.out_pixel, 12);
                end
                ifa.out_ready = 1'b1;
            end
        join
        wait_outs(0, 6);
        exp_q = '{11, 12, 13, 21, 22, 23};
        check_seq(0, "stall", 1);

        // 4: kernel write mid-frame applies from the next frame only
        clear_q();
        stream_px(0, 0, 0, 0, 8);
        idle();
        chk("fill_busy", 32'(busy_a), 1);
        write_kernel(1'b1);
        stream_px(0, 0, 0, 8, 20);
        stream_px(0, 0, 0, 0, 20);
        idle();
        wait_outs(0, 12);
        exp_q = '{11, 12, 13, 21, 22, 23, 99, 108, 117, 189, 198, 207};
        check_seq(0, "b2b", 2);

        // 5: reset mid-frame restores identity and drops the partial frame
        clear_q();
        stream_px(0, 0, 0, 0, 7);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_busy", 32'(busy_a), 0);
        chk("mrst_out_valid", 32'(ifa.out_valid), 0);
        stream_px(0, 0, 0, 0, 20);
        idle();
        wait_outs(0, 6);
        exp_q = '{11, 12, 13, 21, 22, 23};
        check_seq(0, "mrst", 1);

        // 6: FRAC_SH=3 floor shift
        write_kernel(1'b1);
        clear_q();
        stream_px(1, 1, 8, 0, 20);
        stream_px(1, 1, -9, 0, 20);
        idle();
        wait_outs(1, 12);
        exp_q = {};
        for (int i = 0; i < 12; i++) exp_q.push_back(i < 6 ? 9 : -11);
        check_seq(1, "shift", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
Streaming 3x3 2-D convolution engine. Successor to the fully parallel 30x30 MAC-array convolver.
- Accepts one signed pixel per cycle in raster order over a valid/ready handshake.
- Builds the 3x3 window from two internal line buffers and applies a run-time-loadable signed kernel.
- Emits the "valid" (IMG_W-2)x(IMG_H-2) output image with backpressure.
- Sits between the image source (file/DMA feeder) and the downstream pooling/activation stage.

Parameters:
- DATA_W, 13, signed input pixel width
- COEF_W, 13, signed kernel coefficient width
- OUT_W, 13, signed output pixel width after shift/saturate
- IMG_W, 32, pixels per row (>=3)
- IMG_H, 32, rows per frame (>=3)
- FRAC_SH, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
- clk, in, 1, rising-edge clock
- rst_n, in, 1, synchronous active-low reset
- coef_we, in, 1, coefficient write strobe
- coef_addr, in, 4, kernel index 0..8 (row-major, 0 = top-left); 9..15 ignored
- coef_data, in, COEF_W, signed coefficient
- in_valid, in, 1, input pixel valid
- in_ready, out, 1, engine accepts pixel
- in_pixel, in, DATA_W, signed pixel
- out_valid, out, 1, output pixel valid
- out_ready, in, 1, downstream accepts output
- out_pixel, out, OUT_W, signed convolution result
- out_last, out, 1, marks the final output of a frame
- busy, out, 1, frame in progress or pipeline non-empty

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n): sampled only on the rising edge of clk.
- Reset values:
  - out_valid=0, out_pixel=0, out_last=0, busy=0.
  - Row/column counters=0; all pipeline valid bits=0.
  - Kernel bank and active shadow set to identity: coef[4]=1, all others 0.
  - Line buffer contents are not reset; they are don't-care.
- Handshake:
  - advance = !out_valid | out_ready.
  - in_ready = advance, combinational from out_valid/out_ready only.
  - The pipeline moves only when advance=1; on stall every stage holds.
  - out_pixel and out_last stay stable while out_valid=1 and out_ready=0.
- Pixel accept: in_valid & in_ready.
  - Column counter increments on each accept; at IMG_W-1 it wraps to 0 and increments the row counter.
  - Row counter wraps from IMG_H-1 to 0, which is end of frame.
- Window:
  - Two line buffers of IMG_W entries delay by exactly 1 and 2 rows.
  - A 3x3 shift register is fed by {lb2_out, lb1_out, in_pixel} on each accept.
  - A window is valid when the accepted pixel has row>=2 and col>=2.
- Phase states, derived from the counters:
  - FILL: row<2, no outputs.
  - RUN: row>=2.
  - DRAIN: last pixel accepted, outputs still in pipeline.
  - FILL->RUN at the first accept of row 2.
  - RUN->DRAIN at the last accept of the frame.
  - DRAIN->FILL when the pipeline empties, or immediately on the next frame's first accept.
  - busy=1 in RUN, in DRAIN, and in FILL when any pixel has been accepted.
- Pipeline: 3 stages, latency 3 accepted-advance cycles from the accept of the window's bottom-right pixel to out_valid.
  - S1: 9 signed products, width DATA_W+COEF_W.
  - S2: adder tree; ACC_W = DATA_W+COEF_W+4, full precision, no overflow.
  - S3: arithmetic shift right by FRAC_SH (floor), then saturate to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- out_last=1 with the output from window row IMG_H-1, col IMG_W-1.
- Coefficients:
  - A write with coef_we=1 updates the bank register on any cycle, with no stall.
  - The active shadow set copies the bank on the accept of pixel (0,0). The copy uses the pre-write bank value if a write occurs in that same cycle.
  - A frame therefore always uses one consistent kernel, and mid-frame writes take effect at the next frame.
- Simultaneous events:
  - The first accept of frame N+1 may overlap DRAIN of frame N; no bubble is required.
- Reset mid-frame: counters and valid bits clear next edge. The following accepted pixel is (0,0) of a new frame, and no stale outputs are emitted.

Decomposition:
- Package conv_pkg:
  - ACC_W computation
  - signed saturate function (acc -> OUT_W)
  - KERNEL_TAPS=9 constant
  - identity-kernel reset constant
- Sub-module conv_line_buffer: parametrised IMG_W x DATA_W two-row delay with enable, plain registers/inferred RAM, no reset on storage.

Test Plan (IMG_W=5, IMG_H=4 unless stated):
1. Reset then stream pixel=10*r+c with identity kernel, out_ready=1 -> exactly 6 outputs 11,12,13,21,22,23; out_last only on 23; first out_valid 3 cycles after accepting (2,2).
2. Bank all 1s, written before frame, constant pixel 500 -> every output saturates to 4095; constant pixel -500 -> -4096.
3. Test 1 stimulus with out_ready low for 5 cycles after the 2nd output -> in_ready=0 during the stall, out_pixel held at 12, the sequence is still 11..23 with no loss or duplicates.
4. Write all-1s kernel mid-frame 1 (after 8 accepts), then run frame 2 back-to-back -> frame 1 gives identity results; frame 2 gives box sums, first value 99 (sum of 0,1,2,10,11,12,20,21,22).
5. rst_n low for 1 cycle after 7 accepted pixels, then a full frame -> exactly 6 identity outputs 11..23 with no output from the aborted frame; coefficients back at identity.
6. FRAC_SH=3, all-1s kernel, constant pixel 8 -> output 9; constant pixel -9 -> output -11 (floor of -81/8).
